// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and derived totals shared by the scan generator and
// the pixel consumers that compare against body_x/body_y.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    localparam int unsigned CNT_W     = 12;
    // Off-screen coordinate: larger than any visible position, so object compares never hit.
    localparam logic [CNT_W-1:0] OFFSCREEN = 12'hFFF;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } scan_ctl_t;

    localparam scan_ctl_t SCAN_CTL_RST = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

    function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift pipeline with synchronous reset to a configurable value.
module sig_delay #(
    parameter int unsigned       WIDTH   = 1,
    parameter int unsigned       DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel/line counters, registered coordinates, sync and per-frame
// strobes. SYNC_DLY (0-3) lags the sync/active outputs behind the coordinates.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned SYNC_DLY = 1
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    output logic [11:0] body_x,
    output logic [11:0] body_y,
    output logic        video_active,
    output logic        hsync,
    output logic        vsync,
    output logic        move_clock,
    output logic        frame_tick
);

    localparam int unsigned LINE_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned FRAME_LINES = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [11:0] H_LAST   = 12'(LINE_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(FRAME_LINES - 1);
    localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [11:0] h_cnt_q, v_cnt_q;
    logic [11:0] body_x_q, body_y_q;
    logic        move_clock_q, frame_tick_q;
    logic        line_end, frame_end, visible;
    scan_ctl_t   ctl_d, ctl_out;

    assign line_end  = (h_cnt_q == H_LAST);
    assign frame_end = line_end && (v_cnt_q == V_LAST);
    assign visible   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

    always_ff @(posedge vga_clk) begin
        if (sys_rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (line_end) begin
            h_cnt_q <= '0;
            v_cnt_q <= frame_end ? 12'd0 : v_cnt_q + 12'd1;
        end else begin
            h_cnt_q <= h_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst_n) begin
            body_x_q     <= OFFSCREEN;
            body_y_q     <= OFFSCREEN;
            move_clock_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            body_x_q     <= visible ? h_cnt_q : OFFSCREEN;
            body_y_q     <= visible ? v_cnt_q : OFFSCREEN;
            move_clock_q <= (v_cnt_q == V_VIS);
            frame_tick_q <= frame_end;
        end
    end

    always_comb begin
        ctl_d.active = visible;
        ctl_d.hsync  = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
        ctl_d.vsync  = !((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END));
    end

    // First stage aligns with body_x/body_y; the remaining SYNC_DLY stages add the lag.
    sig_delay #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DLY + 1),
        .RST_VAL (SCAN_CTL_RST)
    ) u_ctl_delay (
        .clk  (vga_clk),
        .rst  (sys_rst_n),
        .din  (ctl_d),
        .dout (ctl_out)
    );

    assign body_x       = body_x_q;
    assign body_y       = body_y_q;
    assign move_clock   = move_clock_q;
    assign frame_tick   = frame_tick_q;
    assign video_active = ctl_out.active;
    assign hsync        = ctl_out.hsync;
    assign vsync        = ctl_out.vsync;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: default geometry for reset and one-line checks; a reduced 25x13 geometry
// (SYNC_DLY 0/1/3) for frame, strobe, pixel and mid-frame reset checks.
module tb_vga_scan_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [11:0] d_bx, d_by, s_bx, s_by, z_bx, z_by, t_bx, t_by;
    logic d_va, d_hs, d_vs, d_mc, d_ft;
    logic s_va, s_hs, s_vs, s_mc, s_ft;
    logic z_va, z_hs, z_vs, z_mc, z_ft;
    logic t_va, t_hs, t_vs, t_mc, t_ft;

    vga_scan_gen u_def (
        .vga_clk(clk), .sys_rst_n(rst), .body_x(d_bx), .body_y(d_by), .video_active(d_va),
        .hsync(d_hs), .vsync(d_vs), .move_clock(d_mc), .frame_tick(d_ft)
    );

    vga_scan_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DLY(1)
    ) u_s1 (
        .vga_clk(clk), .sys_rst_n(rst), .body_x(s_bx), .body_y(s_by), .video_active(s_va),
        .hsync(s_hs), .vsync(s_vs), .move_clock(s_mc), .frame_tick(s_ft)
    );

    vga_scan_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DLY(0)
    ) u_s0 (
        .vga_clk(clk), .sys_rst_n(rst), .body_x(z_bx), .body_y(z_by), .video_active(z_va),
        .hsync(z_hs), .vsync(z_vs), .move_clock(z_mc), .frame_tick(z_ft)
    );

    vga_scan_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DLY(3)
    ) u_s3 (
        .vga_clk(clk), .sys_rst_n(rst), .body_x(t_bx), .body_y(t_by), .video_active(t_va),
        .hsync(t_hs), .vsync(t_vs), .move_clock(t_mc), .frame_tick(t_ft)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rst(input string tag, input logic [11:0] bx, input logic [11:0] by,
                             input logic va, input logic hs, input logic vs, input logic mc,
                             input logic ft);
        check({tag, "_bx"}, 32'(bx), 32'hFFF);
        check({tag, "_by"}, 32'(by), 32'hFFF);
        check({tag, "_va"}, 32'(va), 32'd0);
        check({tag, "_hs"}, 32'(hs), 32'd1);
        check({tag, "_vs"}, 32'(vs), 32'd1);
        check({tag, "_mc"}, 32'(mc), 32'd0);
        check({tag, "_ft"}, 32'(ft), 32'd0);
    endtask

    // Reduced geometry model: 25 clocks/line, 13 lines/frame, 16x8 visible.
    function automatic logic small_vis(input int n);
        int m;
        m = n % 325;
        return ((m % 25) < 16) && ((m / 25) < 8);
    endfunction

    initial begin
        int bx_err, va_err, hs_err, hs_low, hs_first;
        int sb_err, sva_err, z_rise, s_rise, t_rise;
        int ft_cnt, ft_first, ft_second, vs_low, mc_rises, mc_first;
        logic [11:0] exp_bx, exp_by;
        logic exp_hs, exp_va, mc_prev;
        int n, h, v;

        // Reset held 5 cycles.
        rst = 1'b1;
        repeat (5) tick();
        check_rst("rst_def", d_bx, d_by, d_va, d_hs, d_vs, d_mc, d_ft);
        check_rst("rst_s1", s_bx, s_by, s_va, s_hs, s_vs, s_mc, s_ft);
        check_rst("rst_s0", z_bx, z_by, z_va, z_hs, z_vs, z_mc, z_ft);
        check_rst("rst_s3", t_bx, t_by, t_va, t_hs, t_vs, t_mc, t_ft);

        // Default geometry: one full line.
        rst = 1'b0;
        bx_err = 0; va_err = 0; hs_err = 0; hs_low = 0; hs_first = -1;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (k == 1) begin
                check("first_bx", 32'(d_bx), 32'd0);
                check("first_by", 32'(d_by), 32'd0);
                check("first_hs", 32'(d_hs), 32'd1);
                check("first_vs", 32'(d_vs), 32'd1);
            end
            exp_bx = (k - 1 < 640) ? 12'(k - 1) : 12'hFFF;
            exp_by = (k - 1 < 640) ? 12'd0 : 12'hFFF;
            exp_hs = !(k >= 2 && (k - 2) >= 656 && (k - 2) <= 751);
            exp_va = (k >= 2) && (k - 2 < 640);
            if (d_bx !== exp_bx || d_by !== exp_by) bx_err++;
            if (d_va !== exp_va) va_err++;
            if (d_hs !== exp_hs) hs_err++;
            if (d_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
        end
        check("line_body", 32'(bx_err), 32'd0);
        check("line_va", 32'(va_err), 32'd0);
        check("line_hs", 32'(hs_err), 32'd0);
        check("hs_low_len", 32'(hs_low), 32'd96);
        check("hs_low_hcnt", 32'(hs_first - 2), 32'd656);

        // Reduced geometry: frames, strobes, delay alignment, pixel.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        sb_err = 0; sva_err = 0; z_rise = -1; s_rise = -1; t_rise = -1;
        ft_cnt = 0; ft_first = -1; ft_second = -1; vs_low = 0; mc_rises = 0; mc_first = -1;
        mc_prev = s_mc;
        for (int k = 1; k <= 700; k++) begin
            tick();
            if (k == 1) check("dly_bx0", 32'(s_bx), 32'd0);
            if (z_va === 1'b1 && z_rise < 0) z_rise = k;
            if (s_va === 1'b1 && s_rise < 0) s_rise = k;
            if (t_va === 1'b1 && t_rise < 0) t_rise = k;
            n = k - 1;
            h = (n % 325) % 25;
            v = (n % 325) / 25;
            exp_bx = small_vis(n) ? 12'(h) : 12'hFFF;
            exp_by = small_vis(n) ? 12'(v) : 12'hFFF;
            if (s_bx !== exp_bx || s_by !== exp_by) sb_err++;
            if (s_va !== ((k >= 2) && small_vis(k - 2))) sva_err++;
            if (s_ft === 1'b1) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = k;
                else if (ft_second < 0) ft_second = k;
            end
            if (k <= 325 && s_vs === 1'b0) vs_low++;
            if (s_mc === 1'b1 && mc_prev === 1'b0) begin
                mc_rises++;
                if (mc_first < 0) mc_first = k;
            end
            mc_prev = s_mc;
            if (k == 140) begin
                check("pix_bx", 32'(s_bx), 32'd14);
                check("pix_by", 32'(s_by), 32'd5);
            end
            if (k == 141) check("pix_va", 32'(s_va), 32'd1);
        end
        check("rise_dly0", 32'(z_rise - 1), 32'd0);
        check("rise_dly1", 32'(s_rise - 1), 32'd1);
        check("rise_dly3", 32'(t_rise - 1), 32'd3);
        check("frame_body", 32'(sb_err), 32'd0);
        check("frame_va", 32'(sva_err), 32'd0);
        check("ft_count", 32'(ft_cnt), 32'd2);
        check("ft_first", 32'(ft_first), 32'd325);
        check("ft_period", 32'(ft_second - ft_first), 32'd325);
        check("vs_low_len", 32'(vs_low), 32'd50);
        check("mc_rises", 32'(mc_rises), 32'd2);
        check("mc_first_v", 32'((mc_first - 1) / 25), 32'd8);

        // Mid-frame reset with counters at (10,3).
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 85; k++) tick();
        check("mid_pre_bx", 32'(s_bx), 32'd9);
        check("mid_pre_by", 32'(s_by), 32'd3);
        rst = 1'b1;
        tick();
        check_rst("mid_rst", s_bx, s_by, s_va, s_hs, s_vs, s_mc, s_ft);
        rst = 1'b0;
        tick();
        check("mid_bx0", 32'(s_bx), 32'd0);
        check("mid_by0", 32'(s_by), 32'd0);
        tick();
        check("mid_bx1", 32'(s_bx), 32'd1);
        check("mid_va1", 32'(s_va), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 The module SHALL have parameter H_SYNC, default 96, hsync width in clocks.
REQ-004 The module SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 The module SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The module SHALL have parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33 (lines).
REQ-007 The module SHALL have parameter SYNC_DLY, default 1, extra pipeline stages on hsync/vsync/video_active; legal range 0-3.
REQ-008 The module SHALL have port vga_clk, input, 1, pixel clock; the only clock.
REQ-009 The module SHALL have port sys_rst_n, input, 1, synchronous active-high reset (port name is historical; high = reset).
REQ-010 The module SHALL have port body_x, output, 12, current pixel column.
REQ-011 The module SHALL have port body_y, output, 12, current pixel row.
REQ-012 The module SHALL have port video_active, output, 1, high while in the visible area.
REQ-013 The module SHALL have port hsync, output, 1, active-low horizontal sync.
REQ-014 The module SHALL have port vsync, output, 1, active-low vertical sync.
REQ-015 The module SHALL have port move_clock, output, 1, once-per-frame game-update strobe (level).
REQ-016 The module SHALL have port frame_tick, output, 1, single-cycle pulse at frame end.

Function
REQ-017 The module SHALL keep h_cnt in 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), incrementing every vga_clk and wrapping to 0.
REQ-018 The module SHALL keep v_cnt in 0..V_TOTAL-1 (525); v_cnt SHALL increment only in the cycle where h_cnt wraps, and wrap to 0 when v_cnt = V_TOTAL-1 in that cycle.
REQ-019 Line and frame wraps in the same cycle SHALL yield h_cnt=0, v_cnt=0 next cycle with no skipped or repeated line.
REQ-020 When h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, body_x/body_y SHALL equal h_cnt/v_cnt, registered, one cycle after the counters.
REQ-021 Outside the visible area, body_x and body_y SHALL both be 12'hFFF, so no on-screen object compare can match.
REQ-022 hsync SHALL be low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), high otherwise.
REQ-023 vsync SHALL be low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), high otherwise.
REQ-024 video_active, hsync and vsync SHALL lag body_x/body_y by exactly SYNC_DLY cycles, aligning with a registered pixel-hit consumer.
REQ-025 move_clock SHALL be high for the whole of line V_ACTIVE (480) and low otherwise, giving one rising edge per frame outside the visible area.
REQ-026 frame_tick SHALL pulse for exactly one cycle when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-027 All outputs SHALL be registered; no combinational path from sys_rst_n to outputs.

Reset
REQ-028 While sys_rst_n is high at a vga_clk edge, h_cnt and v_cnt SHALL be 0 and the delay pipeline SHALL be cleared.
REQ-029 Reset values SHALL be body_x=body_y=12'hFFF, video_active=0, hsync=1, vsync=1, move_clock=0, frame_tick=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame immediately; after release, scanning SHALL restart at (0,0), with the first visible pixel at the first edge after release.

Structure
REQ-031 Default timing constants and derived totals (H_TOTAL, V_TOTAL, sync start/end) SHALL live in shared package vga_timing_pkg, shared with pixel consumers.
REQ-032 The SYNC_DLY pipeline SHALL be one sub-module, sig_delay (parameterised width and depth, synchronous reset to a given value).

Verification
REQ-033 Reset held 5 cycles, then released -> body_x=0, body_y=0 one cycle later; hsync=vsync=1.
REQ-034 Run one line -> body_x counts 0..639, then 12'hFFF for 160 cycles; hsync low for exactly 96 cycles starting at h_cnt 656.
REQ-035 Run one full frame -> 420000 clocks between frame_tick pulses; vsync low for exactly 1600 clocks; one move_clock rising edge at v_cnt 480.
REQ-036 Assert reset at h_cnt 300, v_cnt 200 -> outputs return to reset values next edge; scanning restarts at (0,0).
REQ-037 SYNC_DLY=0 and SYNC_DLY=3 -> video_active rises 0 and 3 cycles after body_x becomes 0 respectively.
REQ-038 Check pixel (632,240) -> body_x=632, body_y=240 with video_active=1 at the SYNC_DLY-aligned cycle; never 12'hFFF in the visible area.
